// File: rtl/iter_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROR by 0..WIDTH-1, applying one
// power-of-two stage per clock, largest stage first, then a one-cycle result pulse.
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               data_ready,
    output logic [WIDTH-1:0]   result
);

    localparam int STAGE_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(SHAMT_W - 1);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic [1:0]           op_q, op_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic [SHAMT_W:0]     step_amt;
    logic [SHAMT_W:0]     ror_back;
    logic [WIDTH-1:0]     stage_out;
    logic                 accept;

    // Stage shift is at most WIDTH/2, so the rotate complement is never zero.
    always_comb begin
        step_amt  = (SHAMT_W + 1)'(1) << stage_q;
        ror_back  = (SHAMT_W + 1)'(WIDTH) - step_amt;
        stage_out = work_q;
        case (op_q)
            OP_SLL:  stage_out = work_q << step_amt;
            OP_SRL:  stage_out = work_q >> step_amt;
            OP_SRA:  stage_out = WIDTH'($signed(work_q) >>> step_amt);
            OP_ROR:  stage_out = (work_q >> step_amt) | (work_q << ror_back);
            default: stage_out = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        shamt_d  = shamt_q;
        op_d     = op_q;
        stage_d  = stage_q;
        result_d = result_q;
        accept   = 1'b0;

        case (state_q)
            S_IDLE: begin
                accept = start;
            end
            S_SHIFT: begin
                if (shamt_q[stage_q]) begin
                    work_d = stage_out;
                end
                if (stage_q == '0) begin
                    state_d  = S_DONE;
                    result_d = work_d;
                end else begin
                    stage_d = stage_q - 1'b1;
                end
            end
            S_DONE: begin
                accept = start;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d = S_SHIFT;
            work_d  = data_in;
            shamt_d = shamt;
            op_d    = op;
            stage_d = LAST_STAGE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            shamt_q  <= '0;
            op_q     <= '0;
            stage_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            shamt_q  <= shamt_d;
            op_q     <= op_d;
            stage_q  <= stage_d;
            result_q <= result_d;
        end
    end

    assign busy       = (state_q == S_SHIFT);
    assign data_ready = (state_q == S_DONE);
    assign result     = result_q;

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised, multi-cycle shifter that generalises the fixed arithmetic shift-right-by-16 stage into a full shift unit.
- Supports a variable shift amount (0..WIDTH-1) and four modes: SLL, SRL, SRA, ROR.
- Applies one log-stage (shift by 2^k) per clock, MSB stage first, behind a start/data_ready handshake.
- Sits beside the ALU as the shift execution unit, the same way the multdiv unit does.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, >= 2.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled at a rising edge only while state is IDLE or DONE.
- op  input  2  mode: 00 SLL, 01 SRL (zero fill), 10 SRA (sign fill from bit WIDTH-1), 11 ROR.
- data_in  input  WIDTH  operand; latched with start.
- shamt  input  SHAMT_W  shift amount; latched with start.
- busy  output  1  high while a shift is in progress.
- data_ready  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  WIDTH  final value; held until the next completion.

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, busy=0, data_ready=0, result=0, internal work/shamt/op/stage registers=0.
- States:
  - IDLE: start=1 -> latch data_in into work, latch shamt and op, set stage=SHAMT_W-1, go to SHIFT.
  - SHIFT: busy=1. Each cycle, if latched shamt[stage]=1, work <= work shifted by 2^stage in the latched mode; otherwise work is unchanged. If stage==0, go to DONE and load result <= next work value. Otherwise stage decrements.
  - DONE: data_ready=1, busy=0, for exactly one cycle. start=1 here -> same action as in IDLE (back-to-back accepted). Otherwise go to IDLE.
- Latency: start high in cycle 0 -> busy high in cycles 1..SHAMT_W -> data_ready high and result valid in cycle SHAMT_W+1 (cycle 6 at default). Fixed latency, independent of shamt and op.
- Throughput: one operation per SHAMT_W+1 cycles.
- start while busy=1 is ignored: no effect on state, latched operands, or result.
- Inputs may change freely after the start cycle; only the latched copies are used.
- shamt=0: result equals data_in exactly, for every op, after the full latency.
- Per-mode stage rules:
  - SRA: fill bits equal the original data_in[WIDTH-1]. The sign is preserved across stages because work[WIDTH-1] never changes under SRA.
  - SRL/SLL: fill with zeros.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
- result updates only on entry to DONE; it keeps its previous value throughout IDLE and SHIFT.
- Reset in any state, including mid-SHIFT: takes effect at that edge with the reset values above. The in-flight operation is discarded, no data_ready pulse is emitted, and result is cleared to 0.
- reset and start both high at the same edge: reset wins; the operation is not accepted.

Test Plan:
- Reset then idle: after reset, busy=0, data_ready=0, result=0; holding start=0 for 10 cycles changes nothing.
- SRA: data_in=0x80000000, shamt=16, op=10 -> data_ready in cycle 6 with result=0xFFFF8000. Also data_in=0x7FFF0000, shamt=16 -> result=0x00007FFF.
- SLL, SRL, ROR:
  - 0x00000001 << 31 (op=00) -> 0x80000000.
  - 0xF0000000 SRL 4 (op=01) -> 0x0F000000.
  - 0x00000001 ROR 1 (op=11) -> 0x80000000.
  - 0x12345678 ROR 8 -> 0x78123456.
- shamt=0 with op=10 on 0x80000001 -> result=0x80000001 after the full 6-cycle latency. Back-to-back: a start asserted in the DONE cycle is accepted, and busy=1 the next cycle.
- start pulsed in cycle 3 with different data while busy -> ignored; the first operation's result is unchanged and no extra data_ready pulse appears.
- reset asserted in cycle 3 of an SLL -> next cycle busy=0, result=0; no data_ready for that operation. A new start afterwards completes normally.
